// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder (generators 111/101) with valid/ready handshakes.
// Define CONV_ENC_TAIL_EN to flush each frame with two zero tail bits; otherwise the shift state streams across frames.
module conv_enc_k3 #(
   parameter int unsigned FRAME_LEN = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_bit,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  tx_pair,
   output logic        out_last,
   output logic [15:0] frame_cnt
);

   localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN - 1);

   logic [1:0]  shift_q;
   logic [1:0]  shift_nxt;
   logic [7:0]  bit_cnt;
   logic [7:0]  bit_cnt_nxt;
   logic [1:0]  tx_nxt;
   logic        valid_nxt;
   logic        last_nxt;
   logic [15:0] fcnt_nxt;
   logic        load_ok;
   logic        in_hs;
   logic        out_hs;

`ifdef CONV_ENC_TAIL_EN
   typedef enum logic {DATA, TAIL} state_t;
   state_t state;
   state_t state_nxt;
   logic   tail_cnt;
   logic   tail_cnt_nxt;

   assign in_ready = (state == DATA) && load_ok;
`else
   assign in_ready = load_ok;
`endif

   // The output register may take a new symbol when it is empty or being drained this cycle.
   assign load_ok = !out_valid || out_ready;
   assign in_hs   = in_valid && in_ready;
   assign out_hs  = out_valid && out_ready;

   always_comb begin
      shift_nxt   = shift_q;
      bit_cnt_nxt = bit_cnt;
      tx_nxt      = tx_pair;
      valid_nxt   = out_valid;
      last_nxt    = out_last;
      fcnt_nxt    = frame_cnt;
`ifdef CONV_ENC_TAIL_EN
      state_nxt    = state;
      tail_cnt_nxt = tail_cnt;
`endif
      if (out_hs && out_last) begin
         fcnt_nxt = frame_cnt + 16'd1;
      end
      if (out_hs) begin
         valid_nxt = 1'b0;
         last_nxt  = 1'b0;
      end
      if (in_hs) begin
         tx_nxt      = {in_bit ^ shift_q[1] ^ shift_q[0], in_bit ^ shift_q[0]};
         shift_nxt   = {in_bit, shift_q[1]};
         valid_nxt   = 1'b1;
         last_nxt    = 1'b0;
         bit_cnt_nxt = bit_cnt + 8'd1;
         if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = 8'd0;
`ifdef CONV_ENC_TAIL_EN
            state_nxt = TAIL;
`else
            last_nxt  = 1'b1;
`endif
         end
      end
`ifdef CONV_ENC_TAIL_EN
      // Tail bits are zeros, so the encoder output reduces to the shift state taps.
      else if (state == TAIL && load_ok) begin
         tx_nxt       = {shift_q[1] ^ shift_q[0], shift_q[0]};
         shift_nxt    = {1'b0, shift_q[1]};
         valid_nxt    = 1'b1;
         last_nxt     = tail_cnt;
         tail_cnt_nxt = ~tail_cnt;
         if (tail_cnt) begin
            state_nxt = DATA;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= 2'b00;
         bit_cnt   <= 8'd0;
         tx_pair   <= 2'b00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_cnt <= 16'd0;
      end else begin
         shift_q   <= shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         tx_pair   <= tx_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
         frame_cnt <= fcnt_nxt;
      end
   end

`ifdef CONV_ENC_TAIL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= DATA;
         tail_cnt <= 1'b0;
      end else begin
         state    <= state_nxt;
         tail_cnt <= tail_cnt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_conv_enc_k3.sv
// Directed bench for conv_enc_k3 (FRAME_LEN=4); expectations follow the CONV_ENC_TAIL_EN build setting.
module tb_conv_enc_k3;

   localparam int FL = 4;
`ifdef CONV_ENC_TAIL_EN
   localparam int NPAIR = FL + 2;
   // Pair sequences packed first-pair-in-MSBs.
   localparam logic [15:0] EXP_1011 = 16'b0000_1110_0001_0111;
   localparam logic [15:0] EXP_0000 = 16'b0000_0000_0000_0000;
`else
   localparam int NPAIR = FL;
   localparam logic [15:0] EXP_1011 = 16'b0000_0000_1110_0001;
   localparam logic [15:0] EXP_0000 = 16'b0000_0000_0111_0000;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready;
   logic        out_valid;
   logic [1:0]  tx_pair;
   logic        out_last;
   logic [15:0] frame_cnt;

   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic        w_out_valid;
   logic [1:0]  w_tx_pair;
   logic        w_out_last;
   logic [15:0] w_frame_cnt;

   int total = 0;
   int bad = 0;
   logic [1:0] got_pair [0:15];
   logic       got_last [0:15];
   int         n_got;

   conv_enc_k3 #(.FRAME_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .tx_pair(tx_pair), .out_last(out_last), .frame_cnt(frame_cnt)
   );

   conv_enc_k3 #(.FRAME_LEN(1)) wrap_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_bit(1'b1),
      .in_ready(w_in_ready), .out_valid(w_out_valid), .out_ready(1'b1),
      .tx_pair(w_tx_pair), .out_last(w_out_last), .frame_cnt(w_frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends nbits (first bit in the MSB of the used field) and records every delivered pair;
   // stall_len holds out_ready low while the first pair waits.
   task automatic apply_stimulus(input logic [7:0] bits, input int nbits, input int npairs, input int stall_len);
      int idx = 0;
      int stalled = 0;
      int cyc = 0;
      n_got = 0;
      while (n_got < npairs && cyc < 100) begin
         @(negedge clk);
         cyc++;
         out_ready = !(out_valid && n_got == 0 && stalled < stall_len);
         in_valid  = (idx < nbits);
         in_bit    = (idx < nbits) ? bits[nbits-1-idx] : 1'b0;
         #1;
         if (!out_ready) begin
            stalled++;
            check_output("stall_pair", 32'(tx_pair), 32'b11);
            check_output("stall_in_ready", 32'(in_ready), 32'd0);
         end
         if (out_valid && out_ready) begin
            got_pair[n_got] = tx_pair;
            got_last[n_got] = out_last;
            if (out_last) check_output("in_ready_at_last", 32'(in_ready), 32'd1);
            n_got++;
         end
         if (in_valid && in_ready) idx++;
      end
      check_output("pair_count", 32'(n_got), 32'(npairs));
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_frame(input string tag, input logic [15:0] exp, input int npairs, input logic [15:0] exp_fc);
      for (int i = 0; i < npairs; i++) begin
         check_output($sformatf("%s_pair%0d", tag, i), 32'(got_pair[i]), 32'(exp[2*(npairs-1-i) +: 2]));
         check_output($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == npairs - 1));
      end
      #1;
      check_output($sformatf("%s_frame_cnt", tag), 32'(frame_cnt), 32'(exp_fc));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int cyc;
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_tx_pair", 32'(tx_pair), 32'd0);
      check_output("rst_out_last", 32'(out_last), 32'd0);
      check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_output("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      apply_stimulus(8'b1011, 4, NPAIR, 0);
      check_frame("a", EXP_1011, NPAIR, 16'd1);

      do_reset();
      apply_stimulus(8'b1011, 4, NPAIR, 3);
      check_frame("b", EXP_1011, NPAIR, 16'd1);

      do_reset();
      apply_stimulus(8'b1011, 4, NPAIR, 0);
      check_frame("c1", EXP_1011, NPAIR, 16'd1);
      apply_stimulus(8'b0000, 4, NPAIR, 0);
      check_frame("c2", EXP_0000, NPAIR, 16'd2);

      // Two bits accepted, then reset lands while the second pair is still undelivered.
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(negedge clk);
      in_bit   = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_output("pre_reset_valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_output("mid_reset_valid", 32'(out_valid), 32'd0);
      check_output("mid_reset_frame_cnt", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(8'b1011, 4, NPAIR, 0);
      check_frame("d", EXP_1011, NPAIR, 16'd1);

`ifndef CONV_ENC_TAIL_EN
      check_output("wrap_start", 32'(w_frame_cnt), 32'd0);
      n = 0;
      cyc = 0;
      w_in_valid = 1'b1;
      while (n < 65535 && cyc < 70000) begin
         @(negedge clk);
         #1;
         cyc++;
         if (w_out_valid && w_out_last) n++;
      end
      check_output("wrap_count", 32'(n), 32'd65535);
      @(negedge clk);
      w_in_valid = 1'b0;
      #1;
      check_output("wrap_ffff", 32'(w_frame_cnt), 32'hFFFF);
      @(negedge clk);
      #1;
      check_output("wrap_zero", 32'(w_frame_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
